// File: rtl/imm_pkg.sv
// Shared opcode and format-code constants for the pipelined immediate generator.
package imm_pkg;

  localparam int FMT_W = 3;

  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;

  localparam logic [FMT_W-1:0] FMT_R   = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I   = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S   = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B   = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U   = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J   = 3'd5;
  localparam logic [FMT_W-1:0] FMT_SH  = 3'd6;
  localparam logic [FMT_W-1:0] FMT_ILL = 3'd7;

  // funct3 values 001 (sll*) and 101 (srl*/sra*) carry a shift amount.
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: format select plus extension to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instr,
  output logic [XLEN-1:0]  imm,
  output logic [FMT_W-1:0] fmt,
  output logic             illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  shamt;
  logic [31:0] imm32;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign shamt  = IS64 ? instr[25:20] : {1'b0, instr[24:20]};

  // Every format fits in 32 bits; shift amounts are small and positive, so one
  // sign extension to XLEN below serves both the sext and zext cases.
  always_comb begin
    imm32 = '0;
    fmt   = FMT_ILL;
    case (opcode)
      OPC_LOAD, OPC_JALR: begin
        fmt   = FMT_I;
        imm32 = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_OPIMM: begin
        if (is_shift(funct3)) begin
          fmt   = FMT_SH;
          imm32 = {26'd0, shamt};
        end else begin
          fmt   = FMT_I;
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
      end
      OPC_OPIMM32: begin
        if (IS64) begin
          if (is_shift(funct3)) begin
            fmt   = FMT_SH;
            imm32 = {27'd0, instr[24:20]};
          end else begin
            fmt   = FMT_I;
            imm32 = {{20{instr[31]}}, instr[31:20]};
          end
        end
      end
      OPC_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      OPC_OP: begin
        fmt = FMT_R;
      end
      OPC_OP32: begin
        if (IS64) begin
          fmt = FMT_R;
        end
      end
      default: begin
        fmt = FMT_ILL;
      end
    endcase
  end

  assign imm     = XLEN'($signed(imm32));
  assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator followed by DEPTH valid/ready register stages carrying a tag.
// Handshake: a transfer happens on a rising edge where valid && ready; valid never
// depends on ready, ready_k = !valid_k || ready_{k+1}, and a stalled valid payload holds.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [FMT_W-1:0] fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int PW = XLEN + FMT_W + 1 + TAG_W;

  logic [XLEN-1:0]  dec_imm;
  logic [FMT_W-1:0] dec_fmt;
  logic             dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_ready;
  logic [PW-1:0]    stage_data [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic          valid_q;
    logic [PW-1:0] data_q;
    logic          up_valid;
    logic [PW-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid = in_valid_i;
      assign up_data  = {dec_imm, dec_fmt, dec_illegal, tag_i};
    end else begin : g_body
      assign up_valid = stage_valid[k-1];
      assign up_data  = stage_data[k-1];
    end

    // Stage k can take data unless it and every stage after it are full and
    // the consumer is stalled; this flat form avoids a self-referencing chain.
    assign stage_ready[k] = out_ready_i || !(&stage_valid[DEPTH-1:k]);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (flush_i) begin
        valid_q <= 1'b0;
      end else if (stage_ready[k]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          data_q <= up_data;
        end
      end
    end

    assign stage_valid[k] = valid_q;
    assign stage_data[k]  = data_q;
  end

  assign in_ready_o  = stage_ready[0];
  assign out_valid_o = stage_valid[DEPTH-1];
  assign {imm_o, fmt_o, illegal_o, tag_o} = stage_data[DEPTH-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus, each with its own scoreboard.
module tb_imm_gen_pipe;

  localparam int DEPTH = 2;
  localparam int TAG_W = 32;
  localparam int W32   = 32 + 3 + 1 + TAG_W;
  localparam int W64   = 64 + 3 + 1 + TAG_W;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] instr;
  logic [31:0] tag;
  logic        flush;
  logic        out_ready;

  logic        rdy32, v32, ill32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [31:0] tag32;
  logic        rdy64, v64, ill64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [31:0] tag64;

  imm_gen_pipe #(.XLEN(32), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy32),
    .instr_i(instr), .tag_i(tag), .flush_i(flush), .out_valid_o(v32),
    .out_ready_i(out_ready), .imm_o(imm32), .fmt_o(fmt32), .illegal_o(ill32),
    .tag_o(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy64),
    .instr_i(instr), .tag_i(tag), .flush_i(flush), .out_valid_o(v64),
    .out_ready_i(out_ready), .imm_o(imm64), .fmt_o(fmt64), .illegal_o(ill64),
    .tag_o(tag64)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  logic [W32-1:0] exp32_q[$];
  logic [W64-1:0] exp64_q[$];
  logic [W32-1:0] mon_e32;
  logic [W64-1:0] mon_e64;
  int n_cmp  = 0;
  int n_fail = 0;
  bit rand_done;

  logic [31:0] tv_ins [10] = '{32'hFFF00093, 32'hFE000EE3, 32'h4030D093, 32'h123450B7,
                               32'h001000EF, 32'h0000007F, 32'h0000003B, 32'h03F09093,
                               32'h01F0909B, 32'hFE112E23};
  logic [63:0] tv_i32 [10] = '{64'hFFFFFFFF, 64'hFFFFFFFC, 64'h3, 64'h12345000,
                               64'h800, 64'h0, 64'h0, 64'h1F, 64'h0, 64'hFFFFFFFC};
  logic [63:0] tv_i64 [10] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h3,
                               64'h12345000, 64'h800, 64'h0, 64'h0, 64'h3F, 64'h1F,
                               64'hFFFFFFFFFFFFFFFC};
  logic [2:0]  tv_f32 [10] = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd5, 3'd7, 3'd7, 3'd6, 3'd7, 3'd2};
  logic [2:0]  tv_f64 [10] = '{3'd1, 3'd3, 3'd6, 3'd4, 3'd5, 3'd7, 3'd0, 3'd6, 3'd6, 3'd2};
  logic [6:0]  opcs [13]   = '{7'h03, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                               7'h6F, 7'h67, 7'h33, 7'h3B, 7'h7F, 7'h0B};

  // Outputs are consumed at the negedge before the edge that transfers them.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (v32) begin
        n_cmp++;
        if (exp32_q.size() == 0) begin
          n_fail++;
          $display("FAIL out32_unexpected: got imm=%h fmt=%0d tag=%h, required no output", imm32, fmt32, tag32);
        end else begin
          mon_e32 = exp32_q.pop_front();
          if ({imm32, fmt32, ill32, tag32} !== mon_e32) begin
            n_fail++;
            $display("FAIL out32: got {imm,fmt,ill,tag}=%h, required %h", {imm32, fmt32, ill32, tag32}, mon_e32);
          end
        end
      end
      if (v64) begin
        n_cmp++;
        if (exp64_q.size() == 0) begin
          n_fail++;
          $display("FAIL out64_unexpected: got imm=%h fmt=%0d tag=%h, required no output", imm64, fmt64, tag64);
        end else begin
          mon_e64 = exp64_q.pop_front();
          if ({imm64, fmt64, ill64, tag64} !== mon_e64) begin
            n_fail++;
            $display("FAIL out64: got {imm,fmt,ill,tag}=%h, required %h", {imm64, fmt64, ill64, tag64}, mon_e64);
          end
        end
      end
    end
  end

  // ---------------- reference decoder ----------------
  function automatic void ref_dec(input logic [31:0] ins, input bit is64,
                                  output logic [63:0] imm, output logic [2:0] fmt);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       sh;
    opc = ins[6:0];
    f3  = ins[14:12];
    sh  = (f3 == 3'b001) || (f3 == 3'b101);
    imm = 64'd0;
    fmt = 3'd7;
    case (opc)
      7'h03, 7'h67: begin fmt = 3'd1; imm = {{52{ins[31]}}, ins[31:20]}; end
      7'h13: begin
        if (sh) begin
          fmt = 3'd6;
          imm = is64 ? {58'd0, ins[25:20]} : {59'd0, ins[24:20]};
        end else begin
          fmt = 3'd1; imm = {{52{ins[31]}}, ins[31:20]};
        end
      end
      7'h1B: begin
        if (is64 && sh) begin fmt = 3'd6; imm = {59'd0, ins[24:20]}; end
        else if (is64) begin fmt = 3'd1; imm = {{52{ins[31]}}, ins[31:20]}; end
      end
      7'h23: begin fmt = 3'd2; imm = {{52{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'h63: begin fmt = 3'd3; imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h37, 7'h17: begin fmt = 3'd4; imm = {{32{ins[31]}}, ins[31:12], 12'd0}; end
      7'h6F: begin fmt = 3'd5; imm = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h33: fmt = 3'd0;
      7'h3B: if (is64) fmt = 3'd0;
      default: ;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [31:0] ins, input logic [31:0] t,
                       input logic [63:0] e32, input logic [63:0] e64,
                       input logic [2:0] f32, input logic [2:0] f64);
    int n;
    n = 0;
    in_valid = 1'b1;
    instr    = ins;
    tag      = t;
    @(negedge clk);
    while (!rdy32 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", rdy32, n);
    end else begin
      exp32_q.push_back({e32[31:0], f32, f32 == 3'd7, t});
      exp64_q.push_back({e64, f64, f64 == 3'd7, t});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_model(input logic [31:0] ins, input logic [31:0] t);
    logic [63:0] a, b;
    logic [2:0]  fa, fb;
    ref_dec(ins, 1'b0, a, fa);
    ref_dec(ins, 1'b1, b, fb);
    drive(ins, t, a, b, fa, fb);
  endtask

  task automatic drain(output bit ok);
    int n;
    n = 0;
    while ((exp32_q.size() != 0 || exp64_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    ok = (n < 200);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    instr = 32'd0; tag = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rdy32, rdy64} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_ready_during: got %b%b, required 11", rdy32, rdy64);
    end
    n_cmp++;
    if ({v32, imm32, fmt32, ill32, tag32, v64, imm64, fmt64, ill64, tag64} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b imm=%h tag=%h / v=%b imm=%h tag=%h, required all 0",
               v32, imm32, tag32, v64, imm64, tag64);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rdy32, rdy64, v32, v64} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_after: got ready=%b%b valid=%b%b, required ready=11 valid=00", rdy32, rdy64, v32, v64);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    int lat;
    bit ok;
    out_ready = 1'b1;
    drive_model(32'h00500093, 32'h100);
    lat = 1;
    while (!v32 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required %0d", lat, DEPTH);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_latency: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    bit ok;
    out_ready = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 10; i++)
      drive(tv_ins[i], 32'h200 + i, tv_i32[i], tv_i64[i], tv_f32[i], tv_f64[i]);
    n_cmp++;
    if (cyc - c0 != 10) begin
      n_fail++;
      $display("FAIL throughput: 10 inputs took %0d cycles, required 10", cyc - c0);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_stream: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    logic [2:0]  fa, fb;
    bit ok;
    out_ready = 1'b0;
    drive_model(32'h00A00113, 32'd1);
    drive_model(32'hFFC10193, 32'd2);
    in_valid = 1'b1; instr = 32'h008000EF; tag = 32'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({rdy32, rdy64, v32, v64} !== 4'b0011 || tag32 !== 32'd1 || tag64 !== 32'd1) begin
        n_fail++;
        $display("FAIL backpressure_hold: got ready=%b%b valid=%b%b tag=%0d/%0d, required ready=00 valid=11 tag=1",
                 rdy32, rdy64, v32, v64, tag32, tag64);
      end
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rdy32 !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b, required 1", rdy32);
    end
    ref_dec(32'h008000EF, 1'b0, a, fa);
    ref_dec(32'h008000EF, 1'b1, b, fb);
    exp32_q.push_back({a[31:0], fa, fa == 3'd7, 32'd3});
    exp64_q.push_back({b, fb, fb == 3'd7, 32'd3});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_backpressure: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  task automatic test_flush();
    int lat;
    bit ok;
    out_ready = 1'b0;
    drive_model(32'h12345037, 32'h21);
    drive_model(32'h00000013, 32'h22);
    in_valid = 1'b1; instr = 32'hFFF00093; tag = 32'h23; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    exp32_q.delete();
    exp64_q.delete();
    n_cmp++;
    if ({v32, v64} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_valid: got %b%b, required 00", v32, v64);
    end
    out_ready = 1'b1;
    drive_model(32'h80000063, 32'h24);
    lat = 1;
    while (!v32 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != DEPTH) begin
      n_fail++;
      $display("FAIL flush_latency: got %0d cycles, required %0d", lat, DEPTH);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_flush: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    drive_model(32'hFFF00093, 32'h31);
    drive_model(32'hFE000EE3, 32'h32);
    in_valid = 1'b1; instr = 32'h001000EF; tag = 32'h33;
    rst = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    exp32_q.delete();
    exp64_q.delete();
    n_cmp++;
    if ({v32, imm32, fmt32, ill32, tag32, v64, imm64, fmt64, ill64, tag64} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got v=%b imm=%h tag=%h / v=%b imm=%h tag=%h, required all 0",
               v32, imm32, tag32, v64, imm64, tag64);
    end
    n_cmp++;
    if ({rdy32, rdy64} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_mid_ready: got %b%b, required 11", rdy32, rdy64);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_model(32'h0040A023, 32'h34);
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_reset_mid: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    bit ok;
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          ins      = $urandom;
          ins[6:0] = opcs[$urandom_range(0, 12)];
          drive_model(ins, 32'h1000 + i);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL drain_random: %0d entries outstanding, required 0", exp32_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised successor to the decode-stage immediate generator. It decodes every RV32I/RV64I immediate format (I, S, B, U, J, shift-amount) from a 32-bit instruction and sign- or zero-extends the result to XLEN. The result passes through DEPTH valid/ready pipeline registers with backpressure and flush. It sits between IF/ID and the ID/EX register, and carries an opaque tag (PC or ROB index) alongside each immediate.

## Interface
- XLEN, 32, datapath width; 32 or 64 only.
- DEPTH, 2, number of register stages; must be 1 or greater.
- TAG_W, 32, width of the passthrough tag.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  instruction offered.
- in_ready_o  out  1  stage 0 can accept this cycle.
- instr_i  in  32  instruction word.
- tag_i  in  TAG_W  passthrough tag.
- flush_i  in  1  discard all in-flight entries.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.
- imm_o  out  XLEN  extended immediate.
- fmt_o  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, ILL=7.
- illegal_o  out  1  the opcode is not decoded (fmt_o==ILL).
- tag_o  out  TAG_W  tag delivered with the result.

## Operation
- Format is selected by opcode instr[6:0]:
  - LOAD 0000011, JALR 1100111 and OP-IMM 0010011 (funct3 other than 001/101) give I: imm = sext(instr[31:20]).
  - OP-IMM with funct3 001/101 gives SH: imm = zext(instr[25:20]) when XLEN=64, zext(instr[24:20]) when XLEN=32.
  - OP-IMM-32 0011011 decodes only when XLEN=64: shifts give SH with 5-bit shamt; other funct3 give I. When XLEN=32 it is ILL.
  - STORE 0100011 gives S: sext({instr[31:25],instr[11:7]}).
  - BRANCH 1100011 gives B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - LUI 0110111 and AUIPC 0010111 give U: sext({instr[31:12],12'b0}).
  - JAL 1101111 gives J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - OP 0110011 and OP-32 0111011 (XLEN=64 only) give R with imm=0.
  - Anything else gives ILL with imm=0 and illegal_o=1.
- Pipeline: stage k holds valid_k and its payload.
  - ready_k = !valid_k || ready_{k+1}. The stage after the last one is out_ready_i. in_ready_o = ready_0.
  - A stage loads from upstream when ready_k is 1. Its valid becomes the upstream valid (in_valid_i for stage 0).
  - When ready_k is 0 the stage holds. Payload is never overwritten while valid and stalled.
- Decode happens before stage 0. Later stages only forward.
- Flush: every valid_k clears on the next edge. An input offered in the flush cycle is dropped. Payload registers may keep stale data.
- Reset: all valid_k=0 and all payload registers=0. So out_valid_o=0, imm_o=0, fmt_o=0, illegal_o=0, tag_o=0. in_ready_o reads 1 during and after reset.
- Reset and flush together: reset governs. Both clear valids.
- A transfer occurs on a rising edge where valid && ready. No bubbles are inserted at full throughput.

## Timing
- Latency is DEPTH cycles from input accept to out_valid_o, with out_ready_i held at 1.
- Throughput is 1 instruction per cycle.
- in_ready_o is combinational from out_ready_i through the chain. This is a ready-chain path only; there is no data path from out_ready_i.
- When full and out_ready_i=0, in_ready_o=0 in the same cycle. Outputs stay stable until the transfer.
- imm_o, fmt_o, illegal_o and tag_o change only on edges where the last stage loads.

## Structure
- Shared package imm_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP32);
  - format codes FMT_R through FMT_ILL;
  - the width constant FMT_W=3.
- Sub-module imm_decode (parameter XLEN) is purely combinational: instr in; imm, fmt, illegal out. It is instantiated once before stage 0.
- Stages are a generate loop over DEPTH of identical valid/payload registers.

## Test plan
- XLEN=32, DEPTH=2, out_ready_i=1. Stream 0xFFF00093, 0xFE000EE3, 0x4030D093, 0x123450B7, 0x001000EF back-to-back. Required outputs, starting 2 cycles later, one per cycle:
  - imm 0xFFFFFFFF/I
  - 0xFFFFFFFC/B
  - 0x00000003/SH
  - 0x12345000/U
  - 0x00000800/J
- Illegal opcode: 0x0000007F gives illegal_o=1, fmt_o=7, imm_o=0. 0x0000003B at XLEN=32 also gives ILL.
- XLEN=64: 0xFFF00093 gives 0xFFFFFFFFFFFFFFFF. 0x03F09093 gives 63/SH. 0x01F0909B (OP-IMM-32 slliw) gives 31/SH.
- Backpressure: fill the pipe with tags 1,2,3 and hold out_ready_i=0 for 5 cycles.
  - in_ready_o=0 once full; tag_o stays 1.
  - After release, tags 1,2,3 appear in order with none lost or duplicated.
- Flush with 2 entries in flight plus an input offered: next cycle out_valid_o=0. The following input emerges DEPTH cycles after its accept.
- Assert rst_i mid-stream with the pipe full: one edge later all outputs read 0 and in_ready_o=1. Asserting flush_i at the same time changes nothing.
